aurora_tx_scheduler: RTL and testbench

//  Sequences the per-cycle TX symbol source feeding the lane datapath (data_controller -> encode_8b10b).

---
 rtl/aurora_tx_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_aurora_tx_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_tx_scheduler.sv
// Aurora TX symbol scheduler.
// Chooses the per-cycle TX symbol source for the lane datapath: init ordered
// sets, idle, SCP/ECP framing, AXI payload or clock-compensation bursts.
// Owns the CC period timer and the AXI-stream ready handshake. A CC burst
// pre-empts payload at any point, including in the middle of a frame, and then
// resumes from the saved return state.
module aurora_tx_scheduler #(
    parameter int CC_PERIOD = 5000,
    parameter int CC_LEN    = 3,
    parameter int TIMER_W   = $clog2(CC_PERIOD)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_channel_init_finished,
    input  logic       i_axi_valid,
    input  logic       i_axi_last,
    output logic       o_axi_ready,
    output logic [2:0] o_sym_sel,
    output logic       o_frame_active,
    output logic       o_cc_active,
    output logic       o_frame_aborted
);

    localparam int CNT_W = (CC_LEN > 1) ? $clog2(CC_LEN) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CC_PERIOD - 1);
    localparam logic [CNT_W-1:0]   BURST_LAST = CNT_W'(CC_LEN - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SCP,
        S_DATA,
        S_ECP,
        S_CC
    } state_t;

    typedef enum logic [2:0] {
        SYM_INIT = 3'd0,
        SYM_IDLE = 3'd1,
        SYM_SCP  = 3'd2,
        SYM_DATA = 3'd3,
        SYM_ECP  = 3'd4,
        SYM_CC   = 3'd5
    } sym_t;

    state_t               r_state;
    state_t               r_ret_state;
    logic [TIMER_W-1:0]   r_timer;
    logic                 r_cc_pending;
    logic [CNT_W-1:0]     r_burst_cnt;
    logic                 r_frame_active;
    logic                 r_frame_aborted;

    state_t               w_next_state;
    state_t               w_next_ret;
    sym_t                 w_sym;
    logic                 w_ready;
    logic                 w_cc_active;
    logic                 w_burst_done;
    logic                 w_link_lost;
    logic                 w_transfer;
    logic                 w_timer_wrap;
    logic                 w_enter_cc;

    // Channel loss only counts once the channel has come up.
    always_comb begin
        w_link_lost  = (r_state != S_INIT) && !i_channel_init_finished;
        w_timer_wrap = (r_timer == TIMER_LAST);
        w_burst_done = (r_burst_cnt == BURST_LAST);
        w_transfer   = i_axi_valid && w_ready;
        w_enter_cc   = (w_next_state == S_CC) && (r_state != S_CC);
    end

    // Next-state, return-state capture and per-cycle symbol/handshake decode.
    always_comb begin
        w_next_state = r_state;
        w_next_ret   = r_ret_state;
        w_sym        = SYM_IDLE;
        w_ready      = 1'b0;
        w_cc_active  = 1'b0;

        case (r_state)
            S_INIT: begin
                w_sym = SYM_INIT;
                if (i_channel_init_finished) begin
                    w_next_state = S_IDLE;
                end
            end

            S_IDLE: begin
                w_sym = SYM_IDLE;
                if (r_cc_pending) begin
                    w_next_state = S_CC;
                    w_next_ret   = S_IDLE;
                end else if (i_axi_valid) begin
                    w_next_state = S_SCP;
                end
            end

            S_SCP: begin
                w_sym = SYM_SCP;
                if (r_cc_pending) begin
                    w_next_state = S_CC;
                    w_next_ret   = S_DATA;
                end else begin
                    w_next_state = S_DATA;
                end
            end

            S_DATA: begin
                // Ready is withheld on the pending cycle so a beat is never
                // accepted on the cycle the FSM leaves for the CC burst.
                w_ready = !r_cc_pending && i_channel_init_finished;
                w_sym   = (i_axi_valid && w_ready) ? SYM_DATA : SYM_IDLE;
                if (r_cc_pending) begin
                    w_next_state = S_CC;
                    w_next_ret   = S_DATA;
                end else if (i_axi_valid && w_ready && i_axi_last) begin
                    w_next_state = S_ECP;
                end
            end

            S_ECP: begin
                // ECP always returns through IDLE, so SCP never directly follows.
                w_sym = SYM_ECP;
                if (r_cc_pending) begin
                    w_next_state = S_CC;
                    w_next_ret   = S_IDLE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end

            S_CC: begin
                w_sym       = SYM_CC;
                w_cc_active = 1'b1;
                if (w_burst_done) begin
                    w_next_state = r_ret_state;
                end
            end

            default: begin
                w_sym        = SYM_INIT;
                w_next_state = S_INIT;
            end
        endcase

        if (w_link_lost) begin
            w_next_state = S_INIT;
        end
    end

    // State and saved return-state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_INIT;
            r_ret_state <= S_IDLE;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret;
        end
    end

    // CC period timer: free-running once the channel is up, flags a burst on wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_link_lost || (r_state == S_INIT)) begin
            r_timer      <= '0;
            r_cc_pending <= 1'b0;
        end else begin
            if (w_timer_wrap) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TIMER_W'(1);
            end

            if (w_timer_wrap) begin
                r_cc_pending <= 1'b1;
            end else if (w_enter_cc) begin
                r_cc_pending <= 1'b0;
            end
        end
    end

    // Counts cycles within a CC burst; idle at zero outside S_CC.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_link_lost) begin
            r_burst_cnt <= '0;
        end else if (r_state == S_CC) begin
            if (w_burst_done) begin
                r_burst_cnt <= '0;
            end else begin
                r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end
        end else begin
            r_burst_cnt <= '0;
        end
    end

    // Frame tracking: set by SCP, cleared by ECP, killed by channel loss.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_active  <= 1'b0;
            r_frame_aborted <= 1'b0;
        end else begin
            r_frame_aborted <= w_link_lost && r_frame_active;
            if (w_link_lost) begin
                r_frame_active <= 1'b0;
            end else if (r_state == S_SCP) begin
                r_frame_active <= 1'b1;
            end else if (r_state == S_ECP) begin
                r_frame_active <= 1'b0;
            end
        end
    end

    assign o_axi_ready     = w_ready;
    assign o_sym_sel       = w_sym;
    assign o_cc_active     = w_cc_active;
    assign o_frame_active  = r_frame_active;
    assign o_frame_aborted = r_frame_aborted;

endmodule

// File: tb/tb_aurora_tx_scheduler.sv
// Directed bench for aurora_tx_scheduler with CC_PERIOD=20, CC_LEN=3.
// Each step drives inputs just after the rising edge, queues the expected
// outputs for that cycle, and compares them at the falling edge.
module tb_aurora_tx_scheduler;

    localparam int CC_PERIOD = 20;
    localparam int CC_LEN    = 3;

    logic       clk;
    logic       rst;
    logic       init;
    logic       valid;
    logic       last;
    logic       ready;
    logic [2:0] sym;
    logic       fa;
    logic       cc;
    logic       fab;

    typedef struct {
        logic [2:0] sym;
        logic       rdy;
        logic       cc;
        logic       fa;
        logic       fab;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int errors   = 0;
    int hs_count = 0;
    int hs_last  = 0;

    aurora_tx_scheduler #(
        .CC_PERIOD(CC_PERIOD),
        .CC_LEN   (CC_LEN)
    ) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_channel_init_finished(init),
        .i_axi_valid            (valid),
        .i_axi_last             (last),
        .o_axi_ready            (ready),
        .o_sym_sel              (sym),
        .o_frame_active         (fa),
        .o_cc_active            (cc),
        .o_frame_aborted        (fab)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, queue expectations, compare at negedge.
    task automatic step(input int i, input int v, input int l,
                        input int e_sym, input int e_rdy, input int e_cc,
                        input int e_fa, input int e_fab, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        init  = (i != 0);
        valid = (v != 0);
        last  = (l != 0);
        e.sym = 3'(e_sym);
        e.rdy = (e_rdy != 0);
        e.cc  = (e_cc != 0);
        e.fa  = (e_fa != 0);
        e.fab = (e_fab != 0);
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sym_sel"},       32'(sym),   32'(e.sym));
            chk({tag, "_axi_ready"},     32'(ready), 32'(e.rdy));
            chk({tag, "_cc_active"},     32'(cc),    32'(e.cc));
            chk({tag, "_frame_active"},  32'(fa),    32'(e.fa));
            chk({tag, "_frame_aborted"}, 32'(fab),   32'(e.fab));
        end
        if ((v != 0) && (ready === 1'b1)) begin
            hs_count++;
            if (l != 0) hs_last++;
        end
    endtask

    // From S_IDLE with no frame open: drop the channel for one cycle and
    // re-init so the next step is the first IDLE cycle with the timer at 0.
    task automatic resync(input string tag);
        step(0, 0, 0, 1, 0, 0, 0, 0, {tag, "_drop"});
        step(1, 0, 0, 0, 0, 0, 0, 0, {tag, "_init"});
    endtask

    int e_sym;
    int e_rdy;
    int e_cc;
    int e_fa;
    int v;
    int l;

    initial begin
        rst   = 1'b1;
        init  = 1'b0;
        valid = 1'b1;
        last  = 1'b0;

        // 1: reset then channel down; nothing leaves INIT, timer held.
        step(0, 1, 0, 0, 0, 0, 0, 0, "t1_rst0");
        step(0, 1, 0, 0, 0, 0, 0, 0, "t1_rst1");
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(0, 1, 0, 0, 0, 0, 0, 0, "t1_init_low");
            chk("t1_timer", 32'(dut.r_timer), 32'd0);
        end

        // 2: channel up, no payload: CC burst on cycles 21..23, 41..43.
        step(1, 0, 0, 0, 0, 0, 0, 0, "t2_init");
        for (int c = 0; c <= 44; c++) begin
            e_cc = ((c >= 21 && c <= 23) || (c >= 41 && c <= 43)) ? 1 : 0;
            step(1, 0, 0, (e_cc != 0) ? 5 : 1, 0, e_cc, 0, 0, "t2_idle_cc");
            if (c == 19) chk("t2_timer19", 32'(dut.r_timer), 32'd19);
        end

        // 3: four-beat frame with valid held high.
        resync("t3");
        hs_count = 0; hs_last = 0;
        step(1, 1, 0, 1, 0, 0, 0, 0, "t3_idle");
        step(1, 1, 0, 2, 0, 0, 0, 0, "t3_scp");
        step(1, 1, 0, 3, 1, 0, 1, 0, "t3_beat1");
        step(1, 1, 0, 3, 1, 0, 1, 0, "t3_beat2");
        step(1, 1, 0, 3, 1, 0, 1, 0, "t3_beat3");
        step(1, 1, 1, 3, 1, 0, 1, 0, "t3_beat4");
        step(1, 0, 0, 4, 0, 0, 1, 0, "t3_ecp");
        step(1, 0, 0, 1, 0, 0, 0, 0, "t3_idle_after");
        chk("t3_beats", 32'(hs_count), 32'd4);
        chk("t3_last",  32'(hs_last),  32'd1);

        // 4: 30-beat frame; timer wraps on cycle 19, CC pre-empts mid-frame.
        resync("t4");
        hs_count = 0; hs_last = 0;
        for (int c = 0; c <= 37; c++) begin
            v = (hs_count < 30) ? 1 : 0;
            l = (hs_count == 29) ? 1 : 0;
            e_sym = 1; e_rdy = 0; e_cc = 0; e_fa = 1;
            if (c == 0)                     begin e_sym = 1; e_fa = 0; end
            else if (c == 1)                begin e_sym = 2; e_fa = 0; end
            else if (c <= 19)               begin e_sym = 3; e_rdy = 1; end
            else if (c == 20)               begin e_sym = 1; end
            else if (c <= 23)               begin e_sym = 5; e_cc = 1; end
            else if (c <= 35)               begin e_sym = 3; e_rdy = 1; end
            else if (c == 36)               begin e_sym = 4; end
            else                            begin e_sym = 1; e_fa = 0; end
            step(1, v, l, e_sym, e_rdy, e_cc, e_fa, 0, "t4_long_frame");
        end
        chk("t4_beats", 32'(hs_count), 32'd30);
        chk("t4_last",  32'(hs_last),  32'd1);

        // 5: channel drops during beat 2; frame aborted, then a fresh frame.
        resync("t5");
        hs_count = 0; hs_last = 0;
        step(1, 1, 0, 1, 0, 0, 0, 0, "t5_idle");
        step(1, 1, 0, 2, 0, 0, 0, 0, "t5_scp");
        step(1, 1, 0, 3, 1, 0, 1, 0, "t5_beat1");
        step(0, 1, 0, 1, 0, 0, 1, 0, "t5_drop_beat2");
        step(1, 1, 0, 0, 0, 0, 0, 1, "t5_abort");
        chk("t5_timer_cleared", 32'(dut.r_timer), 32'd0);
        step(1, 1, 0, 1, 0, 0, 0, 0, "t5_idle2");
        step(1, 1, 0, 2, 0, 0, 0, 0, "t5_scp2");
        step(1, 1, 0, 3, 1, 0, 1, 0, "t5_d1");
        step(1, 1, 1, 3, 1, 0, 1, 0, "t5_d2");
        step(1, 0, 0, 4, 0, 0, 1, 0, "t5_ecp");
        step(1, 0, 0, 1, 0, 0, 0, 0, "t5_idle3");
        chk("t5_beats", 32'(hs_count), 32'd3);

        // 6: back-to-back single-beat frames, valid held through ECP/IDLE.
        resync("t6");
        hs_count = 0; hs_last = 0;
        step(1, 1, 1, 1, 0, 0, 0, 0, "t6_idle");
        step(1, 1, 1, 2, 0, 0, 0, 0, "t6_scp1");
        step(1, 1, 1, 3, 1, 0, 1, 0, "t6_data1");
        step(1, 1, 1, 4, 0, 0, 1, 0, "t6_ecp1");
        step(1, 1, 1, 1, 0, 0, 0, 0, "t6_idle_gap");
        step(1, 1, 1, 2, 0, 0, 0, 0, "t6_scp2");
        step(1, 1, 1, 3, 1, 0, 1, 0, "t6_data2");
        step(1, 0, 0, 4, 0, 0, 1, 0, "t6_ecp2");
        step(1, 0, 0, 1, 0, 0, 0, 0, "t6_idle_end");
        chk("t6_beats", 32'(hs_count), 32'd2);
        chk("t6_last",  32'(hs_last),  32'd2);

        // 7: CC becomes pending in the SCP cycle; burst sits between SCP and DATA.
        resync("t7");
        hs_count = 0; hs_last = 0;
        for (int c = 0; c <= 18; c++) begin
            step(1, 0, 0, 1, 0, 0, 0, 0, "t7_idle");
        end
        step(1, 1, 1, 1, 0, 0, 0, 0, "t7_idle19");
        step(1, 1, 1, 2, 0, 0, 0, 0, "t7_scp_pending");
        step(1, 1, 1, 5, 0, 1, 1, 0, "t7_cc1");
        chk("t7_pending_cleared", 32'(dut.r_cc_pending), 32'd0);
        step(1, 1, 1, 5, 0, 1, 1, 0, "t7_cc2");
        step(1, 1, 1, 5, 0, 1, 1, 0, "t7_cc3");
        step(1, 1, 1, 3, 1, 0, 1, 0, "t7_data");
        step(1, 0, 0, 4, 0, 0, 1, 0, "t7_ecp");
        step(1, 0, 0, 1, 0, 0, 0, 0, "t7_idle_end");
        chk("t7_beats", 32'(hs_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
